// File: rtl/freq_meter.sv
`timescale 1ns/1ps
// Gated frequency meter: counts rising edges of an asynchronous input over a
// fixed gate window and reports the count as four BCD digits with overflow.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       sig_in,
    output logic [3:0] D3,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic       OVF,
    output logic       Valid
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          hist_r;
    logic [1:0]    prime_r;
    logic          armed_r;
    logic [GW-1:0] gate_cnt_r;
    logic [15:0]   bcd_r;
    logic          sticky_r;
    logic [15:0]   d_r;
    logic          ovf_r;
    logic          valid_r;

    logic          edge_s;
    logic          terminal_s;
    logic [15:0]   count_next_s;
    logic          sat_hit_s;

    // Four-digit cascaded BCD increment; a digit rolls 9->0 and carries upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    // Synchronizer, history flop and arming: an edge needs a genuinely sampled low first.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
            prime_r <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
            prime_r <= {prime_r[0], 1'b1};
            armed_r <= armed_r | (prime_r[1] & ~sync2_r);
        end
    end

    assign edge_s     = sync2_r & ~hist_r & armed_r;
    assign terminal_s = (gate_cnt_r == GATE_LAST);

    // Next BCD count for this cycle, saturating at 9999.
    always_comb begin
        count_next_s = bcd_r;
        sat_hit_s    = 1'b0;
        if (edge_s) begin
            if (bcd_r == 16'h9999) begin
                sat_hit_s = 1'b1;
            end else begin
                count_next_s = bcd_inc(bcd_r);
            end
        end else begin
            count_next_s = bcd_r;
        end
    end

    // Free-running gate counter defining back-to-back windows.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            gate_cnt_r <= '0;
        end else if (terminal_s) begin
            gate_cnt_r <= '0;
        end else begin
            gate_cnt_r <= gate_cnt_r + GW'(1);
        end
    end

    // Window accumulation; the terminal cycle's edge closes into the reported result.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            bcd_r    <= 16'h0000;
            sticky_r <= 1'b0;
            d_r      <= 16'h0000;
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else if (terminal_s) begin
            bcd_r    <= 16'h0000;
            sticky_r <= 1'b0;
            d_r      <= count_next_s;
            ovf_r    <= sticky_r | sat_hit_s;
            valid_r  <= 1'b1;
        end else begin
            bcd_r    <= count_next_s;
            sticky_r <= sticky_r | sat_hit_s;
            valid_r  <= 1'b0;
        end
    end

    assign D3    = d_r[15:12];
    assign D2    = d_r[11:8];
    assign D1    = d_r[7:4];
    assign D0    = d_r[3:0];
    assign OVF   = ovf_r;
    assign Valid = valid_r;

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
// Scoreboard bench for freq_meter: three instances (two 10000-cycle gates, one
// 30000-cycle gate) driven in parallel, checked against a per-sample edge model.
module tb_freq_meter;

    typedef struct {
        int cnt;
        int at;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] sig_v;
    logic [3:0] d3_v [3];
    logic [3:0] d2_v [3];
    logic [3:0] d1_v [3];
    logic [3:0] d0_v [3];
    logic       ovf_v [3];
    logic       valid_v [3];

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    int   errors = 0;
    int   checks = 0;
    int   k_m [3];
    int   prev_m [3];
    int   cnt_m [3];
    int   win_m [3];
    int   pc [3];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            freq_meter #(.GATE_CYCLES(gi == 1 ? 30000 : 10000)) u_dut (
                .clk_100MHz(clk),
                .rst       (rst_v[gi]),
                .sig_in    (sig_v[gi]),
                .D3        (d3_v[gi]),
                .D2        (d2_v[gi]),
                .D1        (d1_v[gi]),
                .D0        (d0_v[gi]),
                .OVF       (ovf_v[gi]),
                .Valid     (valid_v[gi])
            );
        end
    endgenerate

    // Rising edges seen by each instance since its reset release.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pc[i] <= rst_v[i] ? pc[i] + 1 : 0;
        end
    end

    function automatic int gate_of(input int id);
        return (id == 1) ? 30000 : 10000;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        int v;
        v = (n > 9999) ? 9999 : n;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] dcat(input int id);
        return {d3_v[id], d2_v[id], d1_v[id], d0_v[id]};
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic check(input string name, input int id, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h, want %0h", name, id, pc[id], act, exp);
        end
    endtask

    task automatic push_exp(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int id, output exp_t e, output bit ok);
        ok = (qsize(id) != 0);
        e  = '{cnt: 0, at: 0};
        if (ok) begin
            case (id)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
        end
    endtask

    task automatic check_zero(input int id);
        check("rst_digits", id, dcat(id), 0);
        check("rst_ovf", id, ovf_v[id], 0);
        check("rst_valid", id, valid_v[id], 0);
    endtask

    task automatic release_rst(input int id);
        @(negedge clk);
        rst_v[id]  = 1'b1;
        k_m[id]    = 0;
        prev_m[id] = 0;
        cnt_m[id]  = 0;
        win_m[id]  = 0;
    endtask

    // mode 0: square wave of period p and phase ph; 1: step high at sample p; 2: random bits.
    // Edge at sample k (low->high, k>=2) is detected in gate slot k+1 and belongs to window (k+1)/G.
    task automatic drive(input int id, input int mode, input int p, input int ph, input int ncyc);
        int   g;
        logic s;
        exp_t e;
        g = gate_of(id);
        for (int n = 0; n < ncyc; n++) begin
            k_m[id]++;
            case (mode)
                0:       s = (((k_m[id] + ph) % p) < (p / 2));
                1:       s = (k_m[id] >= p);
                default: s = 1'($urandom_range(1));
            endcase
            sig_v[id] = s;
            if (s && prev_m[id] == 0 && k_m[id] >= 2) cnt_m[id]++;
            prev_m[id] = int'(s);
            if (k_m[id] == g * (win_m[id] + 1) - 2) begin
                e.cnt = cnt_m[id];
                e.at  = g * (win_m[id] + 1);
                push_exp(id, e);
                win_m[id]++;
                cnt_m[id] = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic monitor(input int id);
        logic [15:0] last_d;
        logic        last_o;
        exp_t        e;
        bit          ok;
        last_d = 16'h0000;
        last_o = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_v[id]) begin
                last_d = 16'h0000;
                last_o = 1'b0;
            end else if (valid_v[id]) begin
                pop_exp(id, e, ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dut%0d cycle %0d: got Valid=1, want no pulse", id, pc[id]);
                end else begin
                    check("digits", id, dcat(id), to_bcd(e.cnt));
                    check("ovf", id, ovf_v[id], (e.cnt > 9999) ? 1 : 0);
                    check("valid_time", id, pc[id], e.at);
                end
                last_d = dcat(id);
                last_o = ovf_v[id];
            end else begin
                check("hold_digits", id, dcat(id), last_d);
                check("hold_ovf", id, ovf_v[id], last_o);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = 3'b000;
        sig_v = 3'b001;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i);
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        fork
            begin
                release_rst(0);
                drive(0, 0, 10, $urandom_range(3), 9998);
                drive(0, 0, 3, $urandom_range(2), 10000);
                drive(0, 0, 3, $urandom_range(2), 10000);
                drive(0, 0, 2, $urandom_range(1), 10000);
                drive(0, 0, 1000, $urandom_range(999), 10000);
                drive(0, 0, 1000, $urandom_range(999), 10000);
            end
            begin
                release_rst(1);
                drive(1, 0, 2, $urandom_range(1), 29998);
                drive(1, 0, 10, $urandom_range(9), 30000);
            end
            begin
                release_rst(2);
                drive(2, 1, 9998, 0, 9998);
                drive(2, 1, 0, 0, 10000);
                drive(2, 2, 0, 0, 10000);
                drive(2, 0, 10, $urandom_range(9), 10000);
                drive(2, 0, 10, $urandom_range(9), 6000);
                rst_v[2] = 1'b0;
                #1;
                check_zero(2);
                repeat (3) @(negedge clk);
                release_rst(2);
                drive(2, 0, 10, $urandom_range(9), 9998);
            end
        join
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) check("pending_windows", i, qsize(i), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
